// File: rtl/rv_timer.sv
// rv_timer: programmable system timer and free-running 64-bit cycle counter.
// The timer is programmed through the X-stage CSR write path. A prescaler
// divides the clock into strobes. Each strobe either advances the count or,
// when the count equals the compare value, fires a registered one-cycle tick.
module rv_timer #(
  parameter logic [11:0] g_csr_ctrl  = 12'h7c0,
  parameter logic [11:0] g_csr_cmp   = 12'h7c1,
  parameter logic [11:0] g_csr_count = 12'h7c2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_is_csr_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  output logic        tick_o,
  output logic [31:0] csr_timer_ctrl_o,
  output logic [31:0] csr_timer_cmp_o,
  output logic [31:0] csr_timer_count_o,
  output logic [63:0] csr_cycles_o
);

  // Architectural state. CTRL is kept as its three meaningful fields only.
  logic        en_q, en_d;
  logic        periodic_q, periodic_d;
  logic [15:0] div_q, div_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] cycles_q, cycles_d;
  logic        tick_q, tick_d;

  logic csr_commit;
  logic wr_ctrl, wr_cmp, wr_count, wr_any;
  logic strobe, step, match;

  // Decode which timer CSR, if any, commits this cycle.
  always_comb begin
    csr_commit = !x_stall_i && !x_kill_i && d_is_csr_i;
    wr_ctrl    = csr_commit && (d_csr_sel_i == g_csr_ctrl);
    wr_cmp     = csr_commit && (d_csr_sel_i == g_csr_cmp);
    wr_count   = csr_commit && (d_csr_sel_i == g_csr_count);
    wr_any     = wr_ctrl || wr_cmp || wr_count;
    // A strobe coinciding with any timer CSR write is dropped: the write wins.
    strobe     = en_q && (presc_q == div_q);
    step       = strobe && !wr_any;
    match      = (count_q == cmp_q);
  end

  // Next-state computation for prescaler, counter, compare, control and tick.
  always_comb begin
    // Prescaler wraps on its strobe, idles at 0 when disabled, and restarts
    // on any CTRL or COUNT write so a new setting begins a full division.
    if (wr_ctrl || wr_count || !en_q || strobe) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    count_d = count_q;
    if (wr_count) begin
      count_d = x_csr_write_value_i;
    end else if (step) begin
      if (match) begin
        if (periodic_q) begin
          count_d = 32'd0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    en_d       = en_q;
    periodic_d = periodic_q;
    div_d      = div_q;
    if (wr_ctrl) begin
      en_d       = x_csr_write_value_i[0];
      periodic_d = x_csr_write_value_i[1];
      div_d      = x_csr_write_value_i[31:16];
    end else if (step && match && !periodic_q) begin
      // One-shot expiry disarms the timer.
      en_d = 1'b0;
    end

    cmp_d = wr_cmp ? x_csr_write_value_i : cmp_q;

    tick_d   = step && match;
    cycles_d = cycles_q + 64'd1;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      div_q      <= 16'd0;
      cmp_q      <= 32'd0;
      count_q    <= 32'd0;
      presc_q    <= 16'd0;
      cycles_q   <= 64'd0;
      tick_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      div_q      <= div_d;
      cmp_q      <= cmp_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      cycles_q   <= cycles_d;
      tick_q     <= tick_d;
    end
  end

  assign tick_o            = tick_q;
  assign csr_timer_ctrl_o  = {div_q, 14'd0, periodic_q, en_q};
  assign csr_timer_cmp_o   = cmp_q;
  assign csr_timer_count_o = count_q;
  assign csr_cycles_o      = cycles_q;

endmodule

// File: tb/tb_rv_timer.sv
// Testbench for rv_timer: a transaction-level timer model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rv_timer;

  localparam logic [11:0] CTRL  = 12'h7c0;
  localparam logic [11:0] CMP   = 12'h7c1;
  localparam logic [11:0] COUNT = 12'h7c2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, kill, is_csr;
  logic [11:0] sel;
  logic [31:0] val;
  logic        tick;
  logic [31:0] ctrl_rd, cmp_rd, count_rd;
  logic [63:0] cycles;

  int checks = 0;
  int errors = 0;

  rv_timer dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .x_stall_i           (stall),
    .x_kill_i            (kill),
    .d_is_csr_i          (is_csr),
    .d_csr_sel_i         (sel),
    .x_csr_write_value_i (val),
    .tick_o              (tick),
    .csr_timer_ctrl_o    (ctrl_rd),
    .csr_timer_cmp_o     (cmp_rd),
    .csr_timer_count_o   (count_rd),
    .csr_cycles_o        (cycles)
  );

  always #5 clk = ~clk;

  // Timer model: what the visible registers must hold after each clock.
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] cmp;
    logic [31:0] count;
    logic [15:0] presc;
    logic [63:0] cycles;
    logic        tick;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t s, logic st, logic kl, logic csr,
                                        logic [11:0] id, logic [31:0] v);
    model_t n;
    logic   commit, w_ctrl, w_cmp, w_count, strobe;
    n       = s;
    commit  = !st && !kl && csr;
    w_ctrl  = commit && id == CTRL;
    w_cmp   = commit && id == CMP;
    w_count = commit && id == COUNT;
    strobe  = s.ctrl[0] && (s.presc == s.ctrl[31:16]);
    n.cycles = s.cycles + 64'd1;
    n.tick   = 1'b0;
    if (!(w_ctrl || w_cmp || w_count) && strobe) begin
      if (s.count == s.cmp) begin
        n.tick = 1'b1;
        if (s.ctrl[1]) n.count = 32'd0;
        else           n.ctrl[0] = 1'b0;
      end else begin
        n.count = s.count + 32'd1;
      end
    end
    n.presc = (!s.ctrl[0] || strobe || w_ctrl || w_count) ? 16'd0 : s.presc + 16'd1;
    if (w_ctrl)  n.ctrl  = v & 32'hFFFF_0003;
    if (w_cmp)   n.cmp   = v;
    if (w_count) n.count = v;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, stall, kill, is_csr, sel, val);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One CSR transaction; called at posedge+1, returns at posedge+1 after commit.
  task automatic csr_wr(input logic [11:0] id, input logic [31:0] v,
                        input logic st, input logic kl);
    is_csr = 1'b1; sel = id; val = v; stall = st; kill = kl;
    @(posedge clk); #1;
    $display("csr write id=%h val=%h stall=%0b kill=%0b -> ctrl=%h cmp=%h count=%h",
             id, v, st, kl, ctrl_rd, cmp_rd, count_rd);
    is_csr = 1'b0; stall = 1'b0; kill = 1'b0;
  endtask

  int ticks_q[$];
  int nticks;

  initial begin
    rst_n = 1'b0; stall = 1'b0; kill = 1'b0; is_csr = 1'b0; sel = '0; val = '0;

    fork
      forever begin
        @(negedge clk);
        check("model_tick",   {63'd0, tick}, {63'd0, m.tick});
        check("model_ctrl",   {32'd0, ctrl_rd},  {32'd0, m.ctrl});
        check("model_cmp",    {32'd0, cmp_rd},   {32'd0, m.cmp});
        check("model_count",  {32'd0, count_rd}, {32'd0, m.count});
        check("model_cycles", cycles, m.cycles);
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_ctrl",  {32'd0, ctrl_rd},  64'd0);
    check("reset_cmp",   {32'd0, cmp_rd},   64'd0);
    check("reset_count", {32'd0, count_rd}, 64'd0);
    check("reset_tick",  {63'd0, tick},     64'd0);

    // Periodic: div=3, cmp=4 -> ticks every 20 cycles.
    csr_wr(CMP, 32'd4, 1'b0, 1'b0);
    csr_wr(CTRL, 32'h0003_0003, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (tick) ticks_q.push_back(i);
    end
    $display("periodic: %0d ticks seen", ticks_q.size());
    check("periodic_nticks", ticks_q.size(), 64'd3);
    if (ticks_q.size() == 3) begin
      check("periodic_t0", ticks_q[0], 64'd20);
      check("periodic_t1", ticks_q[1], 64'd40);
      check("periodic_t2", ticks_q[2], 64'd60);
    end
    @(posedge clk); #1;
    csr_wr(CTRL, 32'd0, 1'b0, 1'b0);

    // One-shot: div=0, cmp=7 -> single tick 8 cycles after the commit edge.
    csr_wr(COUNT, 32'd0, 1'b0, 1'b0);
    csr_wr(CMP, 32'd7, 1'b0, 1'b0);
    csr_wr(CTRL, 32'd1, 1'b0, 1'b0);
    nticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick) begin
        nticks++;
        check("oneshot_tick_cycle", i, 64'd8);
      end
    end
    $display("oneshot: %0d ticks, ctrl=%h count=%h", nticks, ctrl_rd, count_rd);
    check("oneshot_nticks", nticks, 64'd1);
    check("oneshot_ctrl",  {32'd0, ctrl_rd},  64'd0);
    check("oneshot_count", {32'd0, count_rd}, 64'd7);
    @(posedge clk); #1;

    // Stall / kill / unmatched id suppress the CSR commit.
    csr_wr(CMP, 32'h55, 1'b1, 1'b0);
    check("stall_cmp", {32'd0, cmp_rd}, 64'd7);
    csr_wr(CMP, 32'h55, 1'b0, 1'b1);
    check("kill_cmp", {32'd0, cmp_rd}, 64'd7);
    csr_wr(12'h7c3, 32'h55, 1'b0, 1'b0);
    check("unmatched_cmp", {32'd0, cmp_rd}, 64'd7);
    csr_wr(CMP, 32'h55, 1'b0, 1'b0);
    check("commit_cmp", {32'd0, cmp_rd}, 64'h55);

    // Collision: COUNT write in the same cycle as a matching strobe.
    csr_wr(COUNT, 32'd3, 1'b0, 1'b0);
    csr_wr(CMP, 32'd3, 1'b0, 1'b0);
    csr_wr(CTRL, 32'd1, 1'b0, 1'b0);
    csr_wr(COUNT, 32'd0, 1'b0, 1'b0);
    check("collide_count", {32'd0, count_rd}, 64'd0);
    check("collide_tick",  {63'd0, tick},     64'd0);
    @(negedge clk);
    check("collide_tick_n", {63'd0, tick}, 64'd0);
    @(posedge clk); #1;
    check("collide_count_next", {32'd0, count_rd}, 64'd1);
    check("collide_tick_next",  {63'd0, tick},     64'd0);
    csr_wr(CTRL, 32'd0, 1'b0, 1'b0);

    // Wrap: count FFFFFFFE -> FFFFFFFF -> 0 -> 1, tick on the match at 1.
    csr_wr(CMP, 32'd1, 1'b0, 1'b0);
    csr_wr(COUNT, 32'hFFFF_FFFE, 1'b0, 1'b0);
    csr_wr(CTRL, 32'd3, 1'b0, 1'b0);
    nticks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("wrap cycle %0d: count=%h tick=%0b", i, count_rd, tick);
      if (tick) nticks++;
      case (i)
        0: check("wrap_c0", {32'd0, count_rd}, 64'hFFFF_FFFE);
        1: check("wrap_c1", {32'd0, count_rd}, 64'hFFFF_FFFF);
        2: check("wrap_c2", {32'd0, count_rd}, 64'd0);
        3: check("wrap_c3", {32'd0, count_rd}, 64'd1);
        default: check("wrap_tick", {63'd0, tick}, 64'd1);
      endcase
    end
    check("wrap_nticks", nticks, 64'd1);
    @(posedge clk); #1;
    csr_wr(CTRL, 32'd0, 1'b0, 1'b0);

    // Reset mid-count with tick high (div=0, cmp=0, periodic: continuous tick).
    csr_wr(COUNT, 32'd0, 1'b0, 1'b0);
    csr_wr(CMP, 32'd0, 1'b0, 1'b0);
    csr_wr(CTRL, 32'd3, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("cont_tick", {63'd0, tick}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: tick=%0b ctrl=%h cycles=%h", tick, ctrl_rd, cycles);
    check("arst_tick",   {63'd0, tick},     64'd0);
    check("arst_ctrl",   {32'd0, ctrl_rd},  64'd0);
    check("arst_cmp",    {32'd0, cmp_rd},   64'd0);
    check("arst_count",  {32'd0, count_rd}, 64'd0);
    check("arst_cycles", cycles, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_tick", {63'd0, tick}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
